hoene_rgb_manchester_led: RTL and testbench

- Tiny Tapeout user top that receives a Manchester-coded serial RGB command on one of two pins and drives three 10-bit PWM LED outputs.
- Datapath: input selector → low-pass glitch filter → Manchester decoder → 30-bit shift register → RGB PWM generator.
- Sits directly under the TT harness and uses the standard tt_um port set.

---
 rtl/hoene_rgb_manchester_led_if.sv | 28 ++
 rtl/hoene_rgb_manchester_led.sv | 262 ++++++++++++++++++++++++++
 tb/tb_hoene_rgb_manchester_led.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hoene_rgb_manchester_led_if.sv
// rtl/hoene_rgb_manchester_led_if.sv - harness pin bundle for the Manchester RGB LED block
//
// Groups the standard tt_um pin set (everything except clk/rst_n).
//   ena     : harness enable
//   ui_in   : dedicated inputs ([0] in0, [1] in1, [2] testmode)
//   uo_out  : dedicated outputs (PWM, decoder status, selection, frame toggle)
//   uio_in  : bidirectional pins, input side
//   uio_out : bidirectional pins, output side
//   uio_oe  : bidirectional pins, output enables
// master = harness side, slave = design side.
interface hoene_rgb_manchester_led_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/hoene_rgb_manchester_led.sv
// rtl/hoene_rgb_manchester_led.sv - Manchester serial RGB command to three PWM LED outputs
//
// Datapath: input selector -> glitch filter -> Manchester decoder -> 30-bit frame
// shift register -> RGB PWM generator.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : tt_um pin bundle (slave side)
//           ui_in[0] in0, ui_in[1] in1, ui_in[2] testmode
//           uo_out[0..2] red/green/blue PWM, [3] data, [4] bit strobe,
//           [5] decode error, [6] in0selected, [7] frame-latched toggle
//           uio_out / uio_oe tied to 0; ena, uio_in ignored
module hoene_rgb_manchester_led #(
  parameter int HALF_BIT    = 8,
  parameter int SEL_TIMEOUT = 255,
  parameter int PWM_BITS    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  hoene_rgb_manchester_led_if.slave  bus
);

  localparam int IDLE_W     = $clog2(SEL_TIMEOUT + 1);
  localparam int FRAME_BITS = 3 * PWM_BITS;
  localparam int BC_W       = $clog2(FRAME_BITS + 1);

  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SEL_TIMEOUT);
  localparam logic [BC_W-1:0]   FRAME_CNT = BC_W'(FRAME_BITS);
  localparam logic [5:0]        PW_MAX    = 6'd63;
  localparam logic [5:0]        SHORT_MIN = 6'(HALF_BIT / 2);
  localparam logic [5:0]        LONG_MIN  = 6'((3 * HALF_BIT) / 2);
  localparam logic [5:0]        LONG_MAX  = 6'((5 * HALF_BIT) / 2);

  // ------------------------------------------------------------------
  // Input synchronizers and selector
  // ------------------------------------------------------------------
  logic [1:0]        in0_sync_q, in1_sync_q;
  logic              in0_prev_q, in1_prev_q;
  logic              in0_sel_q, in0_sel_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic in0_s, in1_s, in0_edge, in1_edge, sel_edge, oth_edge, sel_in, testmode;

  assign testmode = bus.ui_in[2];
  assign in0_s    = in0_sync_q[1];
  assign in1_s    = in1_sync_q[1];
  assign in0_edge = in0_s ^ in0_prev_q;
  assign in1_edge = in1_s ^ in1_prev_q;
  assign sel_edge = in0_sel_q ? in0_edge : in1_edge;
  assign oth_edge = in0_sel_q ? in1_edge : in0_edge;
  assign sel_in   = in0_sel_q ? in0_s : in1_s;

  always_comb begin
    in0_sel_d = in0_sel_q;
    idle_d    = idle_q;
    if (testmode) begin
      in0_sel_d = 1'b1;
    end else if (idle_q == IDLE_MAX && oth_edge) begin
      in0_sel_d = ~in0_sel_q;
    end
    // Any activity on the selected line, or a change of selection, restarts the idle count.
    if (sel_edge || (in0_sel_d != in0_sel_q)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in0_sync_q <= '0;
      in1_sync_q <= '0;
      in0_prev_q <= 1'b0;
      in1_prev_q <= 1'b0;
      in0_sel_q  <= 1'b1;
      idle_q     <= '0;
    end else begin
      in0_sync_q <= {in0_sync_q[0], bus.ui_in[0]};
      in1_sync_q <= {in1_sync_q[0], bus.ui_in[1]};
      in0_prev_q <= in0_s;
      in1_prev_q <= in1_s;
      in0_sel_q  <= in0_sel_d;
      idle_q     <= idle_d;
    end
  end

  // ------------------------------------------------------------------
  // Glitch filter: 2-bit up/down counter with hysteresis on the extremes
  // ------------------------------------------------------------------
  logic [1:0] flt_cnt_q, flt_cnt_d;
  logic       flt_q, flt_d, flt_prev_q, flt_edge;

  always_comb begin
    flt_cnt_d = flt_cnt_q;
    if (sel_in && flt_cnt_q != 2'd3) begin
      flt_cnt_d = flt_cnt_q + 2'd1;
    end else if (!sel_in && flt_cnt_q != 2'd0) begin
      flt_cnt_d = flt_cnt_q - 2'd1;
    end
    flt_d = flt_q;
    if (flt_cnt_d == 2'd3) begin
      flt_d = 1'b1;
    end else if (flt_cnt_d == 2'd0) begin
      flt_d = 1'b0;
    end
  end

  assign flt_edge = flt_q ^ flt_prev_q;

  // ------------------------------------------------------------------
  // Manchester decoder
  // ------------------------------------------------------------------
  // DEC_MID  : synced, last edge was a mid-bit edge
  // DEC_BOUND: synced, last edge was a bit-boundary edge
  typedef enum logic [1:0] {
    DEC_HUNT  = 2'd0,
    DEC_MID   = 2'd1,
    DEC_BOUND = 2'd2
  } dec_state_e;

  dec_state_e dec_state_q, dec_state_d;
  logic [5:0] pw_cnt_q, pw_cnt_d;
  logic       is_short, is_long;
  logic       bit_stb, err_d, frame_clr, data_d;
  logic       data_q, stb_q, err_q;

  // pw_cnt_q at an edge equals the number of clocks since the previous edge.
  assign is_short = (pw_cnt_q >= SHORT_MIN) && (pw_cnt_q < LONG_MIN);
  assign is_long  = (pw_cnt_q >= LONG_MIN) && (pw_cnt_q <= LONG_MAX);

  always_comb begin
    dec_state_d = dec_state_q;
    pw_cnt_d    = pw_cnt_q;
    bit_stb     = 1'b0;
    err_d       = 1'b0;
    frame_clr   = 1'b0;
    data_d      = data_q;
    if (flt_edge) begin
      pw_cnt_d = 6'd1;
      unique case (dec_state_q)
        DEC_HUNT: begin
          // Entering sync only fixes the phase; the edge itself emits no bit.
          if (is_long) dec_state_d = DEC_MID;
        end
        DEC_MID: begin
          if (is_long) begin
            bit_stb = 1'b1;
          end else if (is_short) begin
            dec_state_d = DEC_BOUND;
          end else begin
            err_d       = 1'b1;
            frame_clr   = 1'b1;
            dec_state_d = DEC_HUNT;
          end
        end
        DEC_BOUND: begin
          if (is_long || is_short) begin
            bit_stb     = 1'b1;
            dec_state_d = DEC_MID;
          end else begin
            err_d       = 1'b1;
            frame_clr   = 1'b1;
            dec_state_d = DEC_HUNT;
          end
        end
        default: dec_state_d = DEC_HUNT;
      endcase
    end else if (pw_cnt_q == PW_MAX) begin
      // Line idle: lose sync quietly and abandon any partial frame.
      dec_state_d = DEC_HUNT;
      frame_clr   = 1'b1;
    end else begin
      pw_cnt_d = pw_cnt_q + 6'd1;
    end
    if (bit_stb) data_d = flt_q;
  end

  // ------------------------------------------------------------------
  // Frame shift register and colour duty registers
  // ------------------------------------------------------------------
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PWM_BITS-1:0]   red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                  frame_tgl_q, frame_tgl_d;

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    red_d       = red_q;
    grn_d       = grn_q;
    blu_d       = blu_q;
    frame_tgl_d = frame_tgl_q;
    if (frame_clr) begin
      bit_cnt_d = '0;
    end else if (bit_stb && bit_cnt_q != FRAME_CNT) begin
      shift_d   = {shift_q[FRAME_BITS-2:0], flt_q};
      bit_cnt_d = bit_cnt_q + BC_W'(1);
      if (bit_cnt_d == FRAME_CNT) begin
        red_d       = shift_d[FRAME_BITS-1 -: PWM_BITS];
        grn_d       = shift_d[2*PWM_BITS-1 -: PWM_BITS];
        blu_d       = shift_d[PWM_BITS-1:0];
        frame_tgl_d = ~frame_tgl_q;
      end
    end
  end

  // ------------------------------------------------------------------
  // PWM generator
  // ------------------------------------------------------------------
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_r_q, pwm_g_q, pwm_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt_q   <= '0;
      flt_q       <= 1'b0;
      flt_prev_q  <= 1'b0;
      dec_state_q <= DEC_HUNT;
      pw_cnt_q    <= '0;
      data_q      <= 1'b0;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      red_q       <= '0;
      grn_q       <= '0;
      blu_q       <= '0;
      frame_tgl_q <= 1'b0;
      pwm_cnt_q   <= '0;
      pwm_r_q     <= 1'b0;
      pwm_g_q     <= 1'b0;
      pwm_b_q     <= 1'b0;
    end else begin
      flt_cnt_q   <= flt_cnt_d;
      flt_q       <= flt_d;
      flt_prev_q  <= flt_q;
      dec_state_q <= dec_state_d;
      pw_cnt_q    <= pw_cnt_d;
      data_q      <= data_d;
      stb_q       <= bit_stb;
      err_q       <= err_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      blu_q       <= blu_d;
      frame_tgl_q <= frame_tgl_d;
      pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
      pwm_r_q     <= (pwm_cnt_q < red_q);
      pwm_g_q     <= (pwm_cnt_q < grn_q);
      pwm_b_q     <= (pwm_cnt_q < blu_q);
    end
  end

  assign bus.uo_out  = {frame_tgl_q, in0_sel_q, err_q, stb_q, data_q, pwm_b_q, pwm_g_q, pwm_r_q};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  logic unused_pins;
  assign unused_pins = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};

endmodule

// File: tb/tb_hoene_rgb_manchester_led.sv
// tb/tb_hoene_rgb_manchester_led.sv - self-checking bench for hoene_rgb_manchester_led
module tb_hoene_rgb_manchester_led;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui;

  hoene_rgb_manchester_led_if bus ();
  assign bus.ui_in  = ui;
  assign bus.ena    = 1'b1;
  assign bus.uio_in = 8'h00;

  hoene_rgb_manchester_led dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output event monitor
  int   stb_n = 0, err_n = 0, tgl_n = 0;
  logic tgl_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.uo_out[4] === 1'b1) stb_n++;
    if (bus.uo_out[5] === 1'b1) err_n++;
    if (bus.uo_out[7] !== tgl_prev) tgl_n++;
    tgl_prev = bus.uo_out[7];
  end

  task automatic clr_mon();
    @(posedge clk);
    stb_n = 0;
    err_n = 0;
    tgl_n = 0;
    @(negedge clk);
  endtask

  // Line waveform as (level, width) runs
  int run_lv[$];
  int run_w[$];

  function automatic void push_run(input int lv, input int w);
    if (run_lv.size() > 0 && run_lv[run_lv.size()-1] == lv)
      run_w[run_w.size()-1] += w;
    else begin
      run_lv.push_back(lv);
      run_w.push_back(w);
    end
  endfunction

  function automatic int half(input bit jit);
    return jit ? int'($urandom_range(H + 2, H - 2)) : H;
  endfunction

  // Idle low, preamble bit (high 2H then low half), 30 data bits MSB first, idle low.
  task automatic build_frame(input logic [29:0] bits, input bit jit);
    run_lv.delete();
    run_w.delete();
    push_run(0, 100);
    push_run(1, 2 * H);
    push_run(0, half(jit));
    for (int i = 29; i >= 0; i--) begin
      push_run(bits[i] ? 0 : 1, half(jit));
      push_run(bits[i] ? 1 : 0, half(jit));
    end
    push_run(0, 100);
  endtask

  task automatic drive_runs(input int ch);
    for (int i = 0; i < run_w.size(); i++) begin
      repeat (run_w[i]) begin
        ui[ch] = run_lv[i][0];
        @(negedge clk);
      end
    end
  endtask

  // Reference decoder working on run widths
  int m_r = 0, m_g = 0, m_b = 0;
  int m_stb, m_err, m_tgl;

  task automatic model_runs();
    bit          synced = 0;
    bit          mid    = 0;
    int          nb     = 0;
    logic [29:0] fr     = '0;
    m_stb = 0;
    m_err = 0;
    m_tgl = 0;
    for (int i = 0; i + 1 < run_w.size(); i++) begin
      int w;
      int lv;
      bit sh;
      bit lg;
      bit emit;
      w    = run_w[i];
      lv   = run_lv[i+1];
      sh   = (w >= H / 2) && (w < 3 * H / 2);
      lg   = (w >= 3 * H / 2) && (w <= 5 * H / 2);
      emit = 0;
      if (w >= 63) begin
        synced = 0;
        nb     = 0;
      end else if (!synced) begin
        if (lg) begin
          synced = 1;
          mid    = 1;
        end
      end else if (lg) begin
        mid  = 1;
        emit = 1;
      end else if (sh) begin
        emit = !mid;
        mid  = !mid;
      end else begin
        m_err++;
        synced = 0;
        nb     = 0;
      end
      if (emit) begin
        m_stb++;
        if (nb < 30) begin
          fr = {fr[28:0], lv[0]};
          nb++;
          if (nb == 30) begin
            m_tgl++;
            m_r = int'(fr[29:20]);
            m_g = int'(fr[19:10]);
            m_b = int'(fr[9:0]);
          end
        end
      end
    end
  endtask

  task automatic measure(output int hr, output int hg, output int hb);
    hr = 0;
    hg = 0;
    hb = 0;
    repeat (1024) begin
      @(negedge clk);
      hr += int'(bus.uo_out[0]);
      hg += int'(bus.uo_out[1]);
      hb += int'(bus.uo_out[2]);
    end
  endtask

  typedef struct {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    int         er;
    int         eg;
    int         eb;
  } vec_t;

  initial begin
    vec_t        vt[4];
    int          hr, hg, hb;
    logic [29:0] bits;

    vt[0] = '{r: 10'h3FF, g: 10'h200, b: 10'h000, er: 1023, eg: 512,  eb: 0};
    vt[1] = '{r: 10'h001, g: 10'h3FE, b: 10'h155, er: 1,    eg: 1022, eb: 341};
    vt[2] = '{r: 10'h000, g: 10'h000, b: 10'h3FF, er: 0,    eg: 0,    eb: 1023};
    vt[3] = '{r: 10'h2AA, g: 10'h0FF, b: 10'h100, er: 682,  eg: 255,  eb: 256};

    // Reset state
    ui    = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_uo", int'(bus.uo_out), 8'h40);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_uo", int'(bus.uo_out), 8'h40);
    check("uio_out", int'(bus.uio_out), 0);
    check("uio_oe", int'(bus.uio_oe), 0);

    // Table-driven frames on in0
    for (int v = 0; v < 4; v++) begin
      build_frame({vt[v].r, vt[v].g, vt[v].b}, 1'b0);
      model_runs();
      clr_mon();
      drive_runs(0);
      check("tbl_toggle", tgl_n, 1);
      check("tbl_err", err_n, 0);
      measure(hr, hg, hb);
      check("tbl_red", hr, vt[v].er);
      check("tbl_green", hg, vt[v].eg);
      check("tbl_blue", hb, vt[v].eb);
    end

    // Randomized frames with half-bit jitter
    for (int n = 0; n < 6; n++) begin
      bits = 30'($urandom);
      build_frame(bits, 1'b1);
      model_runs();
      clr_mon();
      drive_runs(0);
      check("rnd_toggle", tgl_n, m_tgl);
      check("rnd_strobes", stb_n, m_stb);
      check("rnd_err", err_n, m_err);
      measure(hr, hg, hb);
      check("rnd_red", hr, m_r);
      check("rnd_green", hg, m_g);
      check("rnd_blue", hb, m_b);
    end

    // Single-clock glitches on idle in0
    run_lv.delete();
    run_w.delete();
    push_run(0, 20);
    for (int k = 0; k < 5; k++) begin
      push_run(1, 1);
      push_run(0, 6);
    end
    push_run(0, 20);
    clr_mon();
    drive_runs(0);
    check("glitch_strobes", stb_n, 0);
    check("glitch_err", err_n, 0);
    check("glitch_toggle", tgl_n, 0);

    // Long pulse at the upper limit accepted, one clock beyond it is an error
    run_lv.delete();
    run_w.delete();
    push_run(0, 100);
    push_run(1, 2 * H);
    push_run(0, 20);
    push_run(1, 21);
    push_run(0, 100);
    clr_mon();
    drive_runs(0);
    check("err_strobes", stb_n, 1);
    check("err_pulses", err_n, 1);
    check("err_toggle", tgl_n, 0);
    measure(hr, hg, hb);
    check("err_keep_red", hr, m_r);
    check("err_keep_blue", hb, m_b);

    // in0 long idle, frame on in1 switches selection
    ui[2] = 1'b0;
    bits  = 30'($urandom);
    build_frame(bits, 1'b0);
    model_runs();
    clr_mon();
    drive_runs(1);
    check("in1_sel", int'(bus.uo_out[6]), 0);
    check("in1_toggle", tgl_n, 1);
    measure(hr, hg, hb);
    check("in1_red", hr, m_r);
    check("in1_green", hg, m_g);
    check("in1_blue", hb, m_b);

    // testmode forces in0; in1 traffic ignored
    ui[2] = 1'b1;
    repeat (3) @(negedge clk);
    check("tm_sel_now", int'(bus.uo_out[6]), 1);
    build_frame(30'h2AAAAAAA, 1'b0);
    clr_mon();
    drive_runs(1);
    check("tm_sel", int'(bus.uo_out[6]), 1);
    check("tm_toggle", tgl_n, 0);
    check("tm_strobes", stb_n, 0);
    ui[2] = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame
    build_frame(30'h3FFFFFFF, 1'b0);
    fork
      drive_runs(0);
      begin
        repeat (250) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async_uo", int'(bus.uo_out), 8'h40);
        @(negedge clk);
        check("rst_hold_uo", int'(bus.uo_out), 8'h40);
        #2 rst_n = 1'b1;
        stb_n = 0;
        err_n = 0;
        tgl_n = 0;
      end
    join
    check("rst_toggle", tgl_n, 0);
    measure(hr, hg, hb);
    check("rst_red", hr, 0);
    check("rst_green", hg, 0);
    check("rst_blue", hb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
